controlador_int: RTL and testbench
==================================

# controlador_int

Interrupt controller sitting directly upstream of the CPU's `interrupcion` input. It synchronises four asynchronous request lines, edge-detects them into a pending register, and gates them with a CPU-writable mask. It drives a single level interrupt request with a guaranteed low gap after each acknowledge. The CPU programs it from one of its output ports and reads its status back on one of its input ports.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages in each request-line synchroniser; legal values are 2 or greater.
- `PRESC`, default 256: timer prescaler divide ratio in clk cycles; legal values are 2 or greater. Used only with `INT_TIMER_EN`.

Ports:
- `clk` input, 1 bit: system clock; all logic is rising-edge.
- `reset` input, 1 bit: asynchronous, active-low reset (0 = reset).
- `fuentes` input, 4 bits: asynchronous request lines; a rising edge on bit i requests interrupt i.
- `dato_cpu` input, 8 bits: data from a CPU output port (`s`).
- `we_mask` input, 1 bit: on the clk edge, load `mask <= dato_cpu[3:0]`.
- `we_ack` input, 1 bit: on the clk edge, clear every pending bit whose `dato_cpu[3:0]` bit is 1.
- `we_periodo` input, 1 bit: on the clk edge, load the timer reload value from `dato_cpu`. Ignored when the timer is compiled out.
- `estado` output, 8 bits: `{mask[3:0], pending[3:0]}`, fed to a CPU input port (`e`).
- `interrupcion` output, 1 bit: interrupt request to the CPU, registered.

## Operation
- Reset (`reset`=0, asynchronous):
  - all synchroniser and edge flops cleared
  - `pending`=0, `mask`=0, `estado`=0x00, `interrupcion`=0
  - FSM=REPOSO; timer reload, prescaler and counter = 0
- Each `fuentes[i]` passes through a `SYNC_STAGES` synchroniser. A 0→1 on the synchronised value (compared against the previous synchronised value) gives a one-cycle event `ev[i]`.
- Pending bits:
  - `ev[i]`=1 sets `pending[i]`, regardless of `mask`.
  - An ack clears the bit.
  - Set and ack on the same bit in the same cycle: set wins, so the bit stays 1.
- `activa = |(pending & mask)`, combinational.
- FSM (registered; `interrupcion`=1 only in PETICION):
  - REPOSO: if `activa`=1, go to PETICION.
  - PETICION: when `we_ack`=1, go to ESPERA. Otherwise stay.
  - ESPERA: go to REPOSO unconditionally after 1 cycle. `interrupcion`=0 here even if `activa`=1.
- Mask changes:
  - Clearing the mask while in PETICION does not drop the request. Only an ack leaves PETICION.
  - An ack with `dato_cpu[3:0]`=0 still moves the FSM to ESPERA. Pending bits are unchanged, so the request re-asserts after the gap if `activa`=1.
- Multiple strobes in one cycle are all honoured independently; each targets a different register.

## Timing
- `fuentes` edge to `pending` set: `SYNC_STAGES`+1 clk edges.
- `pending` (masked) to `interrupcion`=1: +1 edge. Total latency is `SYNC_STAGES`+2 edges (4 with default parameters).
- `we_ack` edge to `interrupcion`=0: same edge. The guaranteed low window is ≥1 cycle (ESPERA).
- Strobe effects appear in `estado` on the edge after the strobe is sampled.
- Source pulses shorter than 1 clk period may be missed. Sources must stay high ≥ `SYNC_STAGES`+1 cycles and low ≥2 cycles between requests.

## Configuration
Macro `INT_TIMER_EN`.
- Defined: a built-in periodic timer is compiled in and feeds source 0.
  - 8-bit reload register `periodo`, written by `we_periodo`.
  - Each write resets the prescaler and loads the counter with `dato_cpu`.
  - The prescaler emits a tick every `PRESC` cycles. On each tick the counter decrements.
  - On the tick where the counter is 1, the counter reloads from `periodo` and `ev[0]` is ORed with a one-cycle timer event.
  - `periodo`=0 disables the timer: no events, prescaler held at 0.
- Not defined: no timer logic is synthesised. `we_periodo` is ignored, and `pending[0]` is driven only by `fuentes[0]`.

## Test plan
1. Reset check: `reset`=0 mid-operation with `pending`=0xF → `estado`=0x00 and `interrupcion`=0 asynchronously. Hold after release until the first source edge.
2. Masked source: `mask`=0x4, `fuentes[2]` 0→1 → `pending`=0x4 after 3 edges and `interrupcion`=1 after 4 edges. Then `we_ack` with `dato_cpu`=0x04 → `interrupcion`=0 for ≥1 cycle, then `estado`=0x40.
3. Unmasked source: `mask`=0x0, `fuentes[1]` edge → `estado`=0x02, `interrupcion` stays 0. Then write `mask`=0x2 → `interrupcion`=1 two edges later.
4. Set/ack collision: `ev[3]` and `we_ack`(0x08) in the same cycle → `pending[3]` stays 1. FSM goes through ESPERA (1 low cycle), then `interrupcion`=1 again.
5. Timer (`INT_TIMER_EN`, `PRESC`=4): `we_periodo` 0x03, `mask`=0x1 → `pending[0]` set 12 cycles after the write, repeating every 12 cycles. Writing 0x00 stops further events.

Source files
------------

// File: rtl/controlador_int.sv
// rtl/controlador_int.sv - four-source interrupt controller with mask, pending and ack gap.
// Optional periodic timer on source 0 is compiled in with the INT_TIMER_EN macro.
module controlador_int #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESC       = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fuentes,
  input  logic [7:0] dato_cpu,
  input  logic       we_mask,
  input  logic       we_ack,
  input  logic       we_periodo,
  output logic [7:0] estado,
  output logic       interrupcion
);

  typedef enum logic [1:0] {REPOSO, PETICION, ESPERA} fsm_t;

  fsm_t       state_q, state_d;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] prev_q;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] ev_src;
  logic [3:0] ev;
  logic [3:0] ack_bits;
  logic       activa;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= fuentes;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ev_src = sync_q[SYNC_STAGES-1] & ~prev_q;

`ifdef INT_TIMER_EN
  localparam int PW = (PRESC > 2) ? $clog2(PRESC) : 1;

  logic [PW-1:0] presc_q;
  logic [7:0]    periodo;
  logic [7:0]    cnt_q;
  logic          tick;
  logic          tev;

  assign tick = (periodo != 8'd0) && (presc_q == PW'(PRESC - 1));
  // Reload on the tick where the count reaches 1 (or 0, to never wrap).
  assign tev  = tick && (cnt_q <= 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      periodo <= '0;
      cnt_q   <= '0;
    end else if (we_periodo) begin
      periodo <= dato_cpu;
      presc_q <= '0;
      cnt_q   <= dato_cpu;
    end else if (periodo == 8'd0) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) cnt_q <= tev ? periodo : cnt_q - 8'd1;
    end
  end

  assign ev = ev_src | {3'b000, tev};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, we_periodo, dato_cpu[7:4]};
  assign ev = ev_src;
`endif

  assign ack_bits = we_ack ? dato_cpu[3:0] : 4'b0000;

  // A new event in the same cycle as its ack keeps the bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~ack_bits) | ev;
      if (we_mask) mask <= dato_cpu[3:0];
    end
  end

  assign activa = |(pending & mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= REPOSO;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REPOSO:   if (activa) state_d = PETICION;
      PETICION: if (we_ack) state_d = ESPERA;
      ESPERA:   state_d = REPOSO;
      default:  state_d = REPOSO;
    endcase
  end

  assign interrupcion = (state_q == PETICION);
  assign estado       = {mask, pending};

endmodule

// File: tb/tb_controlador_int.sv
// tb/tb_controlador_int.sv - scoreboard bench for controlador_int; timer checks need INT_TIMER_EN.
module tb_controlador_int;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] fuentes = 4'h0;
  logic [7:0] dato_cpu = 8'h00;
  logic       we_mask = 1'b0;
  logic       we_ack = 1'b0;
  logic       we_periodo = 1'b0;
  logic [7:0] estado;
  logic       interrupcion;

  controlador_int #(.SYNC_STAGES(2), .PRESC(4)) dut (
    .clk(clk), .reset(reset), .fuentes(fuentes), .dato_cpu(dato_cpu),
    .we_mask(we_mask), .we_ack(we_ack), .we_periodo(we_periodo),
    .estado(estado), .interrupcion(interrupcion)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] est;
    logic       irq;
    string      name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int applied = 0;
  int errors = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: compares at the falling edge whenever an expectation is due.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      applied++;
      if (q[0].cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", q[0].name, q[0].cyc, cyc);
      end else if (estado !== q[0].est || interrupcion !== q[0].irq) begin
        errors++;
        $display("FAIL %s: estado=%h interrupcion=%b, expected estado=%h interrupcion=%b",
                 q[0].name, estado, interrupcion, q[0].est, q[0].irq);
      end
      void'(q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int k, input logic [7:0] est, input logic irq, input string name);
    exp_t e;
    e.cyc = cyc + k; e.est = est; e.irq = irq; e.name = name;
    q.push_back(e);
  endtask

  task automatic strobe(input logic m, input logic a, input logic p, input logic [7:0] d);
    dato_cpu = d; we_mask = m; we_ack = a; we_periodo = p;
    step(1);
    we_mask = 1'b0; we_ack = 1'b0; we_periodo = 1'b0;
  endtask

  initial begin
    int guard;
    step(2);
    expect_at(0, 8'h00, 1'b0, "reset_init");
    reset = 1'b1;
    step(1);

    // Fill pending, then assert reset mid-cycle and check it clears with no clock edge.
    fuentes = 4'hF;
    expect_at(2, 8'h00, 1'b0, "pend_all_early");
    expect_at(3, 8'h0F, 1'b0, "pend_all");
    step(4);
    fuentes = 4'h0;
    reset = 1'b0;
    expect_at(0, 8'h00, 1'b0, "reset_async");
    step(2);
    reset = 1'b1;
    step(3);
    expect_at(0, 8'h00, 1'b0, "reset_hold");
    step(1);

    // Masked source 2.
    strobe(1'b1, 1'b0, 1'b0, 8'h04);
    expect_at(0, 8'h40, 1'b0, "mask_load");
    fuentes[2] = 1'b1;
    expect_at(2, 8'h40, 1'b0, "t2_sync");
    expect_at(3, 8'h44, 1'b0, "t2_pend");
    expect_at(4, 8'h44, 1'b1, "t2_irq");
    step(4);
    strobe(1'b0, 1'b1, 1'b0, 8'h04);
    expect_at(0, 8'h40, 1'b0, "t2_ack");
    expect_at(1, 8'h40, 1'b0, "t2_gap");
    fuentes[2] = 1'b0;
    step(3);

    // Unmasked source 1, then unmask it.
    strobe(1'b1, 1'b0, 1'b0, 8'h00);
    fuentes[1] = 1'b1;
    expect_at(3, 8'h02, 1'b0, "t3_pend");
    expect_at(5, 8'h02, 1'b0, "t3_noirq");
    step(5);
    strobe(1'b1, 1'b0, 1'b0, 8'h02);
    expect_at(0, 8'h22, 1'b0, "t3_mask");
    expect_at(1, 8'h22, 1'b1, "t3_irq");
    step(1);
    strobe(1'b1, 1'b0, 1'b0, 8'h00);
    expect_at(0, 8'h02, 1'b1, "mask_clr_holds");
    strobe(1'b0, 1'b1, 1'b0, 8'h00);
    expect_at(0, 8'h02, 1'b0, "ack_zero_gap");
    expect_at(2, 8'h02, 1'b0, "ack_zero_idle");
    step(2);
    strobe(1'b0, 1'b1, 1'b0, 8'h02);
    expect_at(0, 8'h00, 1'b0, "t3_clear");
    fuentes[1] = 1'b0;
    step(3);

    // Set/ack collision on bit 3 while in PETICION on bit 2.
    strobe(1'b1, 1'b0, 1'b0, 8'h0C);
    fuentes[2] = 1'b1;
    expect_at(4, 8'hC4, 1'b1, "t4_irq");
    step(4);
    fuentes[3] = 1'b1;
    step(2);
    strobe(1'b0, 1'b1, 1'b0, 8'h08);
    expect_at(0, 8'hCC, 1'b0, "t4_collide");
    expect_at(1, 8'hCC, 1'b0, "t4_low");
    expect_at(2, 8'hCC, 1'b1, "t4_reirq");
    step(2);
    strobe(1'b1, 1'b1, 1'b0, 8'h0C);
    expect_at(0, 8'hC0, 1'b0, "multi_strobe");
    fuentes = 4'h0;
    strobe(1'b1, 1'b0, 1'b0, 8'h00);
    step(3);

`ifdef INT_TIMER_EN
    // Timer: PRESC=4, periodo=3 gives an event every 12 cycles.
    strobe(1'b0, 1'b0, 1'b1, 8'h03);
    expect_at(11, 8'h00, 1'b0, "tmr_early");
    expect_at(12, 8'h01, 1'b0, "tmr_first");
    step(13);
    strobe(1'b0, 1'b1, 1'b0, 8'h01);
    expect_at(0, 8'h00, 1'b0, "tmr_ack");
    expect_at(9, 8'h00, 1'b0, "tmr_early2");
    expect_at(10, 8'h01, 1'b0, "tmr_second");
    step(11);
    strobe(1'b0, 1'b0, 1'b1, 8'h00);
    strobe(1'b0, 1'b1, 1'b0, 8'h01);
    expect_at(0, 8'h00, 1'b0, "tmr_ack2");
    expect_at(15, 8'h00, 1'b0, "tmr_stopped");
    step(16);
`endif

    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      step(1);
      guard++;
    end
    while (q.size() > 0) begin
      applied++;
      errors++;
      $display("FAIL %s: never sampled, expected estado=%h", q[0].name, q[0].est);
      void'(q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
